// File: rtl/paddle_axis_ctrl_pkg.sv
// Shared types and screen geometry for the Pong paddle controller.
package paddle_axis_ctrl_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned STEP_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } paddle_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_t;

endpackage

// File: rtl/paddle_axis_ctrl_accel_fsm.sv
// Hold-to-accelerate state machine: picks the per-tick step and gates movement
// on pause and ai_mode toggles.
module paddle_axis_ctrl_accel_fsm
  import paddle_axis_ctrl_pkg::*;
#(
  parameter int unsigned SPEED_SLOW = 1,
  parameter int unsigned SPEED_FAST = 3,
  parameter int unsigned HOLD_TICKS = 16
) (
  input  logic              clk_1ms,
  input  logic              reset,
  input  logic [1:0]        dir,
  input  logic              pause,
  input  logic              ai_mode,
  output logic [1:0]        state,
  output logic [STEP_W-1:0] step_c,
  output logic              move_c
);

  localparam int unsigned CNT_W = $clog2(HOLD_TICKS) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_TICKS - 1);

  paddle_state_t    st;
  dir_t             d;
  dir_t             last_dir;
  logic [CNT_W-1:0] hold_cnt;
  logic             ai_q;
  logic             ai_toggle;

  assign d         = dir_t'(dir);
  assign ai_toggle = (ai_mode != ai_q);
  assign move_c    = (d != NONE) && !pause && !ai_toggle;
  assign step_c    = (st == FAST) ? STEP_W'(SPEED_FAST) : STEP_W'(SPEED_SLOW);
  assign state     = st;

  // Pause and mode toggles override everything; hold_cnt saturates at CNT_MAX.
  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      st       <= IDLE;
      hold_cnt <= '0;
      last_dir <= NONE;
      ai_q     <= 1'b0;
    end else begin
      ai_q <= ai_mode;
      if (move_c) last_dir <= d;
      if (pause || ai_toggle) begin
        st       <= IDLE;
        hold_cnt <= '0;
      end else begin
        case (st)
          IDLE: begin
            if (d != NONE) begin
              st       <= SLOW;
              hold_cnt <= '0;
            end
          end
          SLOW: begin
            if (d == NONE) begin
              st <= IDLE;
            end else if (d != last_dir) begin
              hold_cnt <= '0;
            end else if (hold_cnt == CNT_MAX && !ai_mode) begin
              st <= FAST;
            end else if (hold_cnt != CNT_MAX) begin
              hold_cnt <= hold_cnt + CNT_W'(1);
            end
          end
          FAST: begin
            if (d == NONE) begin
              st <= IDLE;
            end else if (d != last_dir) begin
              st       <= SLOW;
              hold_cnt <= '0;
            end
          end
          default: begin
            st       <= IDLE;
            hold_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/paddle_axis_ctrl.sv
// Single-player paddle: direction decode (manual or AI), saturating vertical
// position update, and the per-pixel paddle window for the VGA mux.
module paddle_axis_ctrl
  import paddle_axis_ctrl_pkg::*;
#(
  parameter int unsigned PADDLE_W    = 6,
  parameter int unsigned PADDLE_H    = 60,
  parameter int unsigned X_CENTER    = 19,
  parameter int unsigned SPEED_SLOW  = 1,
  parameter int unsigned SPEED_FAST  = 3,
  parameter int unsigned HOLD_TICKS  = 16,
  parameter int unsigned AI_DEADBAND = 4,
  parameter logic [11:0] COLOR       = 12'hFFF
) (
  input  logic        clk_1ms,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        pause,
  input  logic        ai_mode,
  input  logic [9:0]  y_ball,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic        paddle_on,
  output logic [11:0] rgb_paddle,
  output logic [9:0]  x_paddle,
  output logic [9:0]  y_paddle,
  output logic [1:0]  state
);

  localparam logic [10:0] HALF_W = 11'(PADDLE_W / 2);
  localparam logic [10:0] HALF_H = 11'(PADDLE_H / 2);
  localparam logic [10:0] Y_MIN  = 11'(PADDLE_H / 2);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - PADDLE_H / 2);
  localparam logic [10:0] DB     = 11'(AI_DEADBAND);

  dir_t              dir;
  logic [STEP_W-1:0] step_c;
  logic              move_c;
  logic [10:0]       yp11, xp11, yb11, step11, px11, py11;
  logic [9:0]        y_next;

  assign yp11   = {1'b0, y_paddle};
  assign xp11   = {1'b0, x_paddle};
  assign yb11   = {1'b0, y_ball};
  assign px11   = {1'b0, x};
  assign py11   = {1'b0, y};
  assign step11 = 11'(step_c);

  paddle_axis_ctrl_accel_fsm #(
    .SPEED_SLOW (SPEED_SLOW),
    .SPEED_FAST (SPEED_FAST),
    .HOLD_TICKS (HOLD_TICKS)
  ) u_fsm (
    .clk_1ms (clk_1ms),
    .reset   (reset),
    .dir     (dir),
    .pause   (pause),
    .ai_mode (ai_mode),
    .state   (state),
    .step_c  (step_c),
    .move_c  (move_c)
  );

  // AI tracks the ball outside a deadband; manual treats both buttons as none.
  always_comb begin
    dir = NONE;
    if (ai_mode) begin
      if (yb11 > yp11 + DB)      dir = DOWN;
      else if (yb11 + DB < yp11) dir = UP;
    end else begin
      if (btn_up && !btn_down)      dir = UP;
      else if (btn_down && !btn_up) dir = DOWN;
    end
  end

  // Bounds are tested before subtracting so the 11-bit result never wraps.
  always_comb begin
    y_next = y_paddle;
    if (move_c) begin
      if (dir == UP)
        y_next = (yp11 >= Y_MIN + step11) ? 10'(yp11 - step11) : 10'(Y_MIN);
      else if (dir == DOWN)
        y_next = (yp11 + step11 <= Y_MAX) ? 10'(yp11 + step11) : 10'(Y_MAX);
    end
  end

  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      y_paddle <= 10'(V_ACTIVE / 2);
      x_paddle <= 10'(X_CENTER);
    end else begin
      y_paddle <= y_next;
      x_paddle <= 10'(X_CENTER);
    end
  end

  // Half-open window rewritten as x+W/2 >= xc so nothing underflows near column 0.
  assign paddle_on = (px11 < 11'(H_ACTIVE)) && (py11 < 11'(V_ACTIVE)) &&
                     (px11 + HALF_W >= xp11) && (px11 < xp11 + HALF_W) &&
                     (py11 + HALF_H >= yp11) && (py11 < yp11 + HALF_H);

  assign rgb_paddle = COLOR;

endmodule

// File: tb/tb_paddle_axis_ctrl.sv
// Directed plus randomized checks of paddle_axis_ctrl against a run-length
// reference model of the acceleration and clamp rules.
module tb_paddle_axis_ctrl;

  localparam int HOLD = 16;
  localparam int SLOW_PX = 1;
  localparam int FAST_PX = 3;
  localparam int DB = 4;
  localparam int YMIN = 30;
  localparam int YMAX = 450;

  logic        clk_1ms, reset, btn_up, btn_down, pause, ai_mode;
  logic [9:0]  y_ball, x, y;
  logic        paddle_on;
  logic [11:0] rgb_paddle;
  logic [9:0]  x_paddle, y_paddle;
  logic [1:0]  state;

  int n_checks = 0;
  int n_pass = 0;

  // Model: position, length of the current same-direction move run, last move direction.
  int m_y, m_run, m_last, m_ai_prev, m_ai;

  paddle_axis_ctrl dut (
    .clk_1ms    (clk_1ms),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .pause      (pause),
    .ai_mode    (ai_mode),
    .y_ball     (y_ball),
    .x          (x),
    .y          (y),
    .paddle_on  (paddle_on),
    .rgb_paddle (rgb_paddle),
    .x_paddle   (x_paddle),
    .y_paddle   (y_paddle),
    .state      (state)
  );

  initial clk_1ms = 1'b0;
  always #5 clk_1ms = ~clk_1ms;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %0d, expected %0d", tag, got, want);
  endtask

  function automatic int exp_state();
    if (m_run == 0) return 0;
    if (m_run >= HOLD + 1 && m_ai == 0) return 2;
    return 1;
  endfunction

  task automatic model_reset();
    m_y = 240; m_run = 0; m_last = 0; m_ai_prev = 0; m_ai = 0;
  endtask

  task automatic model_step(input int up, input int dn, input int ps, input int ai, input int yb);
    int d, stp;
    if (ai != 0) d = (yb > m_y + DB) ? 2 : ((yb + DB < m_y) ? 1 : 0);
    else         d = (up != 0 && dn == 0) ? 1 : ((dn != 0 && up == 0) ? 2 : 0);
    m_ai = ai;
    if (ps != 0 || ai != m_ai_prev || d == 0) begin
      m_run = 0;
    end else begin
      stp = (m_run >= HOLD + 1 && ai == 0) ? FAST_PX : SLOW_PX;
      if (d == 1) m_y = (m_y - stp < YMIN) ? YMIN : m_y - stp;
      else        m_y = (m_y + stp > YMAX) ? YMAX : m_y + stp;
      m_run = (m_run > 0 && d == m_last) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
      m_last = d;
    end
    m_ai_prev = ai;
  endtask

  task automatic pix_check(input int px, input int py);
    logic want;
    x = 10'(px); y = 10'(py);
    #1;
    want = (px >= 16 && px < 22 && py >= m_y - 30 && py < m_y + 30);
    check("paddle_on", 32'(paddle_on), 32'(want));
  endtask

  task automatic tick(input int up, input int dn, input int ps, input int ai, input int yb);
    btn_up = (up != 0); btn_down = (dn != 0); pause = (ps != 0); ai_mode = (ai != 0);
    y_ball = 10'(yb);
    model_step(up, dn, ps, ai, yb);
    @(posedge clk_1ms);
    #1;
    check("y_paddle", 32'(y_paddle), 32'(m_y));
    check("state", 32'(state), 32'(exp_state()));
  endtask

  task automatic async_reset();
    #1 reset = 1'b1;
    #1;
    model_reset();
    check("rst_y", 32'(y_paddle), 32'd240);
    check("rst_state", 32'(state), 32'd0);
    #1 reset = 1'b0;
  endtask

  initial begin
    int py, seg_len, up, dn, ps, ai, yb;
    reset = 1'b1; btn_up = 0; btn_down = 0; pause = 0; ai_mode = 0;
    y_ball = 10'd0; x = 10'd0; y = 10'd0;
    model_reset();
    repeat (2) @(posedge clk_1ms);
    #2;
    check("reset_y", 32'(y_paddle), 32'd240);
    check("reset_x", 32'(x_paddle), 32'd19);
    check("reset_state", 32'(state), 32'd0);
    check("rgb", 32'(rgb_paddle), 32'hFFF);
    @(negedge clk_1ms);
    reset = 1'b0;

    // Acceleration from rest
    for (int i = 1; i <= 20; i++) begin
      tick(1, 0, 0, 0, 0);
      if (i == 16) check("slow_at_16", 32'(state), 32'd1);
      if (i == 17) check("fast_after_17", 32'(state), 32'd2);
    end
    check("accel_y", 32'(y_paddle), 32'd214);

    // Top clamp in FAST
    repeat (58) tick(1, 0, 0, 0, 0);
    check("at_40", 32'(y_paddle), 32'd40);
    tick(1, 0, 0, 0, 0); check("top_37", 32'(y_paddle), 32'd37);
    tick(1, 0, 0, 0, 0); check("top_34", 32'(y_paddle), 32'd34);
    tick(1, 0, 0, 0, 0); check("top_31", 32'(y_paddle), 32'd31);
    tick(1, 0, 0, 0, 0); check("top_30", 32'(y_paddle), 32'd30);
    tick(1, 0, 0, 0, 0); check("top_30_hold", 32'(y_paddle), 32'd30);
    tick(0, 0, 0, 0, 0); check("release_idle", 32'(state), 32'd0);

    // Bottom clamp
    repeat (200) tick(0, 1, 0, 0, 0);
    check("bottom_450", 32'(y_paddle), 32'd450);
    check("bottom_fast", 32'(state), 32'd2);
    tick(0, 0, 0, 0, 0);

    // Both buttons and pause
    repeat (5) tick(1, 1, 0, 0, 0);
    check("both_y", 32'(y_paddle), 32'd450);
    check("both_idle", 32'(state), 32'd0);
    repeat (20) tick(1, 0, 0, 0, 0);
    check("pre_pause", 32'(y_paddle), 32'd424);
    repeat (3) tick(1, 0, 1, 0, 0);
    check("pause_y", 32'(y_paddle), 32'd424);
    check("pause_idle", 32'(state), 32'd0);
    tick(1, 0, 0, 0, 0);
    check("unpause_slow_y", 32'(y_paddle), 32'd423);
    check("unpause_slow_st", 32'(state), 32'd1);
    repeat (17) tick(1, 0, 0, 0, 0);
    check("refast", 32'(state), 32'd2);

    // Async reset between edges
    async_reset();

    // AI tracking
    repeat (110) tick(0, 0, 0, 1, 300);
    check("ai_296", 32'(y_paddle), 32'd296);
    check("ai_idle", 32'(state), 32'd0);
    repeat (110) tick(0, 0, 0, 1, 200);
    check("ai_204", 32'(y_paddle), 32'd204);
    tick(0, 0, 0, 0, 0);

    // Pixel window at the reset position
    async_reset();
    pix_check(16, 210);
    pix_check(21, 269);
    pix_check(15, 240);
    pix_check(22, 240);
    pix_check(19, 209);
    pix_check(19, 270);

    // Randomized segments of held inputs
    ai = 0;
    for (int s = 0; s < 80; s++) begin
      seg_len = int'($urandom_range(1, 25));
      up = int'($urandom_range(0, 1));
      dn = int'($urandom_range(0, 1));
      ps = ($urandom_range(0, 9) == 0) ? 1 : 0;
      if ($urandom_range(0, 5) == 0) ai = 1 - ai;
      yb = int'($urandom_range(0, 479));
      for (int k = 0; k < seg_len; k++) begin
        tick(up, dn, ps, ai, yb);
        py = m_y - 35 + int'($urandom_range(0, 70));
        pix_check(int'($urandom_range(10, 28)), py);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
